// File: rtl/axi_instr_rom_slave_pkg.sv
// Shared AXI encodings for the instruction ROM responder.
package axi_instr_rom_slave_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  function automatic logic wrap_len_ok(
    input logic [7:0] len
  );
    return (len == 8'd1) || (len == 8'd3) ||
           (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_instr_rom_slave_skid_buf.sv
// Two-entry R-channel buffer; head entry is registered so it
// stays stable while the master stalls.
module axi_rd_skid_buf #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  input  logic         i_ready,
  output logic [1:0]   o_level
);

  logic [W-1:0] r_ent [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_pop;

  assign o_valid = (r_cnt != 2'd0);
  assign o_data  = r_ent[r_rp];
  assign o_level = r_cnt;
  assign w_pop   = o_valid & i_ready;

  // Writer never pushes into a full buffer; the top meters issue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ent[0] <= '0;
      r_ent[1] <= '0;
      r_wp     <= 1'b0;
      r_rp     <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_valid) begin
        r_ent[r_wp] <= i_data;
        r_wp        <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, i_valid} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/axi_instr_rom_slave.sv
// AXI4 read-only instruction memory: bursts of reads at one beat
// per cycle, writes drained and answered SLVERR.
module axi_instr_rom_slave
  import axi_instr_rom_slave_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_BYTES  = 2**16,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = '0,
  parameter string INIT_FILE = ""
) (
  input  logic                    i_aclk,
  input  logic                    i_areset_n,
  input  logic [ID_WIDTH-1:0]     i_arid,
  input  logic [ADDR_SIZE-1:0]    i_araddr,
  input  logic [7:0]              i_arlen,
  input  logic [2:0]              i_arsize,
  input  logic [1:0]              i_arburst,
  input  logic                    i_arvalid,
  output logic                    o_arready,
  output logic [ID_WIDTH-1:0]     o_rid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [1:0]              o_rresp,
  output logic                    o_rlast,
  output logic                    o_rvalid,
  input  logic                    i_rready,
  input  logic [ID_WIDTH-1:0]     i_awid,
  input  logic [ADDR_SIZE-1:0]    i_awaddr,
  input  logic [7:0]              i_awlen,
  input  logic [2:0]              i_awsize,
  input  logic [1:0]              i_awburst,
  input  logic                    i_awvalid,
  output logic                    o_awready,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  input  logic                    i_wlast,
  input  logic                    i_wvalid,
  output logic                    o_wready,
  output logic [ID_WIDTH-1:0]     o_bid,
  output logic [1:0]              o_bresp,
  output logic                    o_bvalid,
  input  logic                    i_bready
);

  typedef enum logic {R_IDLE, R_BURST} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(BYTES);
  localparam int DEPTH  = MEM_BYTES / BYTES;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int MEM_LG = $clog2(MEM_BYTES);
  localparam int BW     = ID_WIDTH + DATA_WIDTH + 3;
  localparam logic [ADDR_SIZE-1:0] A_ONE = 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  function automatic logic [ADDR_SIZE-1:0] f_next(
    input logic [ADDR_SIZE-1:0] addr,
    input logic [2:0]           size,
    input logic [7:0]           len,
    input logic [1:0]           burst
  );
    logic [ADDR_SIZE-1:0] step;
    logic [ADDR_SIZE-1:0] alig;
    logic [ADDR_SIZE-1:0] span;
    logic [ADDR_SIZE-1:0] nxt;
    step = A_ONE << size;
    alig = addr & ~(step - A_ONE);
    span = (ADDR_SIZE'(len) + A_ONE) << size;
    nxt  = alig + step;
    case (burst)
      FIXED:   nxt = addr;
      WRAP:    nxt = (addr & ~(span - A_ONE)) |
                     (nxt & (span - A_ONE));
      default: ;
    endcase
    return nxt;
  endfunction

  rstate_t               r_rst;
  rstate_t               w_rnxt;
  wstate_t               r_wst;
  wstate_t               w_wnxt;
  logic                  r_live;
  logic [ID_WIDTH-1:0]   r_arid;
  logic [ADDR_SIZE-1:0]  r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_slverr;
  logic                  r_done;
  logic                  r_s1v;
  logic [BW-1:0]         r_s1;
  logic [ID_WIDTH-1:0]   r_awid;

  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_aw_hs;
  logic                  w_ar_bad;
  logic                  w_issue;
  logic                  w_inrange;
  logic                  w_last;
  logic [ADDR_SIZE-1:0]  w_off;
  logic [1:0]            w_lvl;
  logic [2:0]            w_room;
  logic [BW-1:0]         w_rbeat;
  logic [DATA_WIDTH-1:0] w_rdat;
  logic [1:0]            w_rresp;
  logic                  w_unused;

  assign w_ar_hs   = i_arvalid & o_arready;
  assign w_r_hs    = o_rvalid & i_rready;
  assign w_aw_hs   = i_awvalid & o_awready;
  assign w_off     = r_addr - BASE_ADDR;
  assign w_inrange = (w_off >> MEM_LG) == '0;
  assign w_last    = (r_cnt == r_len);

  assign w_ar_bad = (i_arsize > 3'(LSB)) |
                    (i_arburst == 2'b11) |
                    ((i_arburst == WRAP) &
                     ~wrap_len_ok(i_arlen));

  // Issue only if the beat will still fit once it leaves r_s1.
  assign w_room  = {1'b0, w_lvl} + {2'b0, r_s1v} -
                   {2'b0, w_r_hs};
  assign w_issue = (r_rst == R_BURST) & ~r_done &
                   (w_room <= 3'd1);

  always_comb begin
    w_rdat  = '0;
    w_rresp = OKAY;
    if (r_slverr)
      w_rresp = SLVERR;
    else if (!w_inrange)
      w_rresp = DECERR;
    else
      w_rdat = r_mem[w_off[LSB +: IDX_W]];
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) r_live <= 1'b0;
    else             r_live <= 1'b1;
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_arid   <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_size   <= '0;
      r_burst  <= '0;
      r_slverr <= 1'b0;
      r_done   <= 1'b0;
      r_s1v    <= 1'b0;
      r_s1     <= '0;
    end else begin
      r_s1v <= w_issue;
      if (w_ar_hs) begin
        r_arid   <= i_arid;
        r_addr   <= i_araddr;
        r_len    <= i_arlen;
        r_cnt    <= '0;
        r_size   <= i_arsize;
        r_burst  <= i_arburst;
        r_slverr <= w_ar_bad;
        r_done   <= 1'b0;
      end else if (w_issue) begin
        r_s1   <= {r_arid, w_rdat, w_rresp, w_last};
        r_addr <= f_next(r_addr, r_size, r_len, r_burst);
        r_cnt  <= r_cnt + 8'd1;
        r_done <= w_last;
      end
    end
  end

  axi_rd_skid_buf #(
    .W (BW)
  ) u_skid (
    .i_clk   (i_aclk),
    .i_rst_n (i_areset_n),
    .i_valid (r_s1v),
    .i_data  (r_s1),
    .o_valid (o_rvalid),
    .o_data  (w_rbeat),
    .i_ready (i_rready),
    .o_level (w_lvl)
  );

  assign o_rid   = w_rbeat[BW-1 -: ID_WIDTH];
  assign o_rdata = w_rbeat[DATA_WIDTH+2 -: DATA_WIDTH];
  assign o_rresp = w_rbeat[2:1];
  assign o_rlast = w_rbeat[0] & o_rvalid;

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) r_rst <= R_IDLE;
    else             r_rst <= w_rnxt;
  end

  always_comb begin
    w_rnxt = r_rst;
    unique case (r_rst)
      R_IDLE:  if (w_ar_hs) w_rnxt = R_BURST;
      R_BURST: if (w_r_hs & o_rlast) w_rnxt = R_IDLE;
      default: w_rnxt = R_IDLE;
    endcase
  end

  always_comb begin
    o_arready = r_live & (r_rst == R_IDLE);
  end

  always_ff @(posedge i_aclk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      r_wst  <= W_IDLE;
      r_awid <= '0;
    end else begin
      r_wst <= w_wnxt;
      if (w_aw_hs) r_awid <= i_awid;
    end
  end

  always_comb begin
    w_wnxt = r_wst;
    unique case (r_wst)
      W_IDLE: if (w_aw_hs) w_wnxt = W_DATA;
      W_DATA: if (i_wvalid & i_wlast) w_wnxt = W_RESP;
      W_RESP: if (i_bready) w_wnxt = W_IDLE;
      default: w_wnxt = W_IDLE;
    endcase
  end

  always_comb begin
    o_awready = r_live & (r_wst == W_IDLE);
    o_wready  = (r_wst == W_DATA);
    o_bvalid  = (r_wst == W_RESP);
    o_bresp   = (r_wst == W_RESP) ? SLVERR : OKAY;
    o_bid     = r_awid;
  end

  assign w_unused = ^{i_awaddr, i_awlen, i_awsize,
                      i_awburst, i_wdata, i_wstrb, w_off};

endmodule
